// File: rtl/width_packer_pkg.sv
// Shared types for the width packer: accumulator occupancy classes.
package width_packer_pkg;

    typedef enum logic [1:0] {
        ACC_EMPTY,
        ACC_FILLING,
        ACC_FULL
    } acc_state_e;

endpackage

// File: rtl/width_packer.sv
// Packs narrow input beats LSB-first into wide words through an accumulator
// and a one-word output register, with flush for partial words.
module width_packer
    import width_packer_pkg::*;
#(
    parameter int INPUT_WIDTH  = 1,
    parameter int OUTPUT_WIDTH = 8
) (
    input  logic                                             clk,
    input  logic                                             reset_n,
    input  logic                                             data_in_put,
    output logic                                             data_in_free,
    input  logic [INPUT_WIDTH-1:0]                           data_in,
    input  logic                                             flush,
    output logic                                             data_out_put,
    input  logic                                             data_out_free,
    output logic [OUTPUT_WIDTH-1:0]                          data_out,
    output logic [$clog2(OUTPUT_WIDTH/INPUT_WIDTH+1)-1:0]    data_out_beats
);

    localparam int BEATS = OUTPUT_WIDTH / INPUT_WIDTH;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BEATS);

    generate
        if ((OUTPUT_WIDTH % INPUT_WIDTH) != 0 || OUTPUT_WIDTH <= INPUT_WIDTH) begin : g_bad_width
            $error("width_packer: OUTPUT_WIDTH must be a multiple of INPUT_WIDTH and larger than it");
        end
    endgenerate

    logic [OUTPUT_WIDTH-1:0] acc_data_q, acc_data_d;
    logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]        out_beats_q, out_beats_d;
    logic                    out_valid_q, out_valid_d;

    acc_state_e              acc_state;
    logic                    accept;
    logic                    out_slot_free;
    logic [OUTPUT_WIDTH-1:0] beat_ext;
    logic [OUTPUT_WIDTH-1:0] merged;
    logic [CNT_W-1:0]        eff_cnt;
    logic                    word_done;
    logic                    flush_req;
    logic                    hand_off;

    always_comb begin
        if (acc_cnt_q == '0) begin
            acc_state = ACC_EMPTY;
        end else if (acc_cnt_q == FULL_CNT) begin
            acc_state = ACC_FULL;
        end else begin
            acc_state = ACC_FILLING;
        end
    end

    assign data_in_free = (acc_state != ACC_FULL) && !flush_pend_q;

    always_comb begin
        accept        = data_in_put && data_in_free;
        out_slot_free = !out_valid_q || data_out_free;
        beat_ext      = OUTPUT_WIDTH'(data_in);
        merged        = acc_data_q;
        if (accept) begin
            merged = acc_data_q | (beat_ext << (acc_cnt_q * INPUT_WIDTH));
        end
        // The beat arriving with flush is counted first, so a completing beat
        // turns the flush into an ordinary full-word handoff.
        eff_cnt   = acc_cnt_q + CNT_W'(accept);
        word_done = (eff_cnt == FULL_CNT);
        flush_req = flush_pend_q || (flush && (eff_cnt != '0) && !word_done);
        hand_off  = (word_done || flush_req) && out_slot_free;

        acc_data_d   = merged;
        acc_cnt_d    = eff_cnt;
        flush_pend_d = flush_req;
        out_data_d   = out_data_q;
        out_beats_d  = out_beats_q;
        out_valid_d  = out_valid_q && !data_out_free;

        if (hand_off) begin
            out_data_d   = merged;
            out_beats_d  = eff_cnt;
            out_valid_d  = 1'b1;
            acc_data_d   = '0;
            acc_cnt_d    = '0;
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_data_q   <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_beats_q  <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            acc_data_q   <= acc_data_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_beats_q  <= out_beats_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign data_out_put   = out_valid_q;
    assign data_out       = out_data_q;
    assign data_out_beats = out_beats_q;

endmodule

// File: doc/width_packer.md
WIDTH_PACKER -- requirements
Module: width_packer

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 1: narrow input beat width in bits.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 8: packed word width; must be an integer multiple of INPUT_WIDTH, and greater than INPUT_WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_in_put  input  1  producer offers a beat.
REQ-006 SHALL have port data_in_free  output  1  packer can accept a beat this cycle.
REQ-007 SHALL have port data_in  input  INPUT_WIDTH  beat data.
REQ-008 SHALL have port flush  input  1  emit the current partial word.
REQ-009 SHALL have port data_out_put  output  1  packed word available.
REQ-010 SHALL have port data_out_free  input  1  consumer takes the word this cycle.
REQ-011 SHALL have port data_out  output  OUTPUT_WIDTH  packed word.
REQ-012 SHALL have port data_out_beats  output  clog2(BEATS+1)  number of valid beats in data_out; BEATS = OUTPUT_WIDTH/INPUT_WIDTH.

Function
REQ-013 Input transfer SHALL occur on a rising edge where data_in_put && data_in_free; output transfer SHALL occur on an edge where data_out_put && data_out_free.
REQ-014 Packing SHALL be LSB-first: the first accepted beat of a word lands in data_out[INPUT_WIDTH-1:0], beat k in bits [(k+1)*INPUT_WIDTH-1 : k*INPUT_WIDTH].
REQ-015 Storage SHALL be an accumulator (data + beat counter 0..BEATS) and a one-word output register (data, beat count, valid).
REQ-016 On the edge accepting beat BEATS of a word, the word SHALL move into the output register if it is empty or being taken on that same edge; data_out_put SHALL assert the following cycle (latency 1 from last beat).
REQ-017 Otherwise the full word SHALL remain in the accumulator (state FULL) and move to the output register on the edge the output word is taken.
REQ-018 data_in_free SHALL be low exactly when the accumulator is FULL or a flush is pending; it SHALL NOT combinationally depend on data_in_put.
REQ-019 Sustained throughput SHALL be one beat per cycle when data_out_free is held high.
REQ-020 Accumulator states SHALL be EMPTY (count 0), FILLING (1..BEATS-1), FULL (BEATS, output busy); counter returns to 0 on the edge its word moves to the output register.
REQ-021 flush in EMPTY SHALL be ignored; flush in FULL SHALL be ignored.
REQ-022 flush in FILLING SHALL move the partial word to the output register, unused upper bits zero, data_out_beats = count; if the output register is busy, a flush-pending flag SHALL hold the request and complete on the edge the output word is taken.
REQ-023 flush and an accepted beat on the same edge SHALL include that beat in the flushed word; if that beat completes the word, it SHALL be treated as a normal full word.
REQ-024 data_out and data_out_beats SHALL be stable while data_out_put is high and data_out_free is low.
REQ-025 Full words SHALL report data_out_beats = BEATS.

Reset
REQ-026 While reset_n is low: data_out_put=0, data_out=0, data_out_beats=0, accumulator count=0, flush-pending=0; data_in_free=1 after release.
REQ-027 Reset asserted mid-word or with a word pending SHALL discard all held data; first word after release starts at beat 0.

Structure
REQ-028 BEATS and counter width SHALL be localparams in the module; no shared package entries or typedefs are required.
REQ-029 Single module, no sub-modules; an elaboration-time check SHALL reject OUTPUT_WIDTH not a multiple of INPUT_WIDTH.

Verification (INPUT_WIDTH=1, OUTPUT_WIDTH=8)
REQ-030 Bits 1,0,1,1,0,0,1,0 on consecutive cycles, data_out_free=1 -> data_out=8'h4D, beats=8, data_out_put one cycle after last bit.
REQ-031 Three back-to-back words with data_out_free=1 -> no data_in_free deassertion, three words out.
REQ-032 data_out_free=0, send 16 bits -> first word held stable, data_in_free drops after bit 16; raise free -> both words in order.
REQ-033 Bits 1,1,0 then flush -> data_out=8'h03, beats=3; flush with count 0 -> no output.
REQ-034 Pulse reset_n low after 5 bits -> no output; next 8 bits 8'hFF -> data_out=8'hFF, beats=8.
